// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: default width, FSM encoding
// and digit-count helpers.
package serial_subtractor_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int DIGIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // A single-digit configuration still needs a 1-bit counter to stay legal.
   function automatic int cnt_bits(input int width, input int digit);
      return (width / digit > 1) ? $clog2(width / digit) : 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between a producer (master) and the
// serial subtractor (slave).
interface serial_subtractor_if #(
   parameter int WIDTH = serial_subtractor_pkg::WIDTH_DEF
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_A;
   logic [WIDTH-1:0] data_B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   result;
   logic             overflow;

   modport master (
      output in_valid, data_A, data_B, out_ready,
      input  in_ready, out_valid, result, overflow
   );

   modport slave (
      input  in_valid, data_A, data_B, out_ready,
      output in_ready, out_valid, result, overflow
   );

endinterface

// File: rtl/serial_subtractor_sub_digit.sv
// DIGIT-wide ripple of full-adder cells; the caller supplies inverted B and the
// carry-in, so this slice performs one digit of A - B. Purely combinational.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module sub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b_n,
   input  logic             i_cin,
   output logic [DIGIT-1:0] o_sum,
   output logic             o_cout
);

   logic [DIGIT:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      full_adder u_fa (
         .i_a    (i_a[i]),
         .i_b    (i_b_n[i]),
         .i_cin  (w_c[i]),
         .o_sum  (o_sum[i]),
         .o_cout (w_c[i+1])
      );
   end

   assign o_cout = w_c[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A - B, DIGIT bits per clock; signed overflow flag only with SERIAL_SUB_OVERFLOW_EN.
// Latency: out_valid rises WIDTH/DIGIT edges after acceptance; one op per WIDTH/DIGIT + 2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no input-to-output paths.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIGIT = DIGIT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int             NDIG = num_digits(WIDTH, DIGIT);
   localparam int             CW   = cnt_bits(WIDTH, DIGIT);
   localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

   if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_subtractor: DIGIT must divide WIDTH");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_out_valid;
   logic [WIDTH:0]   r_result;

   logic [DIGIT-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_a_next;
   logic             w_last;

   sub_digit #(.DIGIT(DIGIT)) u_digit (
      .i_a    (r_a[DIGIT-1:0]),
      .i_b_n  (~r_b[DIGIT-1:0]),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // r_a doubles as the difference register: consumed digits shift out the
   // bottom while sum digits enter at the top, so it holds diff after NDIG steps.
   if (DIGIT == WIDTH) begin : g_one_digit
      assign w_a_next = w_sum;
   end else begin : g_multi_digit
      assign w_a_next = {w_sum, r_a[WIDTH-1:DIGIT]};
   end

   assign w_last = (r_cnt == LAST);

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic r_ovf;
   // On the last digit the low digits of r_a/r_b are the operands' top digits.
   logic w_ovf;
   assign w_ovf = (r_a[DIGIT-1] ^ r_b[DIGIT-1]) & (w_sum[DIGIT-1] ^ r_a[DIGIT-1]);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.data_A;
                  r_b     <= bus.data_B;
                  r_carry <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a     <= w_a_next;
               r_b     <= r_b >> DIGIT;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_result    <= {~w_cout, w_a_next};
`ifdef SERIAL_SUB_OVERFLOW_EN
                  r_ovf       <= w_ovf;
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE) && !rst;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign bus.overflow  = r_ovf;
`else
   assign bus.overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed operand pairs with hand-computed
// results, checked by an independent output monitor.
module tb_serial_subtractor;

   localparam int W = 32;

`ifdef SERIAL_SUB_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W:0] res;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic exp_t mk(input logic [W:0] res, input logic ovf_signed);
      exp_t e;
      e.res = res;
      e.ovf = ovf_signed & OVF_EN;
      return e;
   endfunction

   // Monitor: a result is consumed at the edge after a negedge showing valid & ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output: result %h with no pending operation", bus.result);
            end else begin
               e = sb_q.pop_front();
               chk("result", 64'(bus.result), 64'(e.res));
               chk("overflow", 64'(bus.overflow), 64'(e.ovf));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded 100000 time units");
      $fatal(1, "watchdog");
   end

   task automatic wait_in_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL in_ready_timeout: in_ready stayed 0 for 40 cycles, expected 1");
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] res, input logic ovf, input string name);
      bit ok;
      int lat;
      wait_in_ready(ok);
      bus.data_A   = a;
      bus.data_B   = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(mk(res, ovf));
      #1;
      bus.in_valid = 1'b0;
      bus.data_A   = ~a;
      bus.data_B   = ~b;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         if (bus.out_valid) break;
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'd8);
   endtask

   initial begin
      bit ok;
      int gap;
      bus.in_valid  = 1'b0;
      bus.data_A    = '0;
      bus.data_B    = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_overflow", 64'(bus.overflow), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

      run_op(32'd10, 32'd3, 33'h0_0000_0007, 1'b0, "sub_10_3");
      run_op(32'd0, 32'd1, {1'b1, 32'hFFFF_FFFF}, 1'b0, "sub_0_1");
      run_op(32'h8000_0000, 32'd1, {1'b0, 32'h7FFF_FFFF}, 1'b1, "sub_min_1");
      run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, {1'b1, 32'h8000_0000}, 1'b1, "sub_max_m1");
      run_op(32'h7FFF_FFFF, 32'h8000_0000, {1'b1, 32'hFFFF_FFFF}, 1'b1, "sub_max_min");

      // in_valid held high across two operations: second accept waits for DONE->IDLE.
      wait_in_ready(ok);
      bus.data_A   = 32'hDEAD_BEEF;
      bus.data_B   = 32'hDEAD_BEEF;
      bus.in_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(mk(33'h0, 1'b0));
      gap = 0;
      while (gap < 30) begin
         @(negedge clk);
         gap++;
         if (bus.in_ready) break;
      end
      chk("b2b_accept_interval", 64'(gap), 64'd10);
      @(posedge clk);
      sb_q.push_back(mk(33'h0, 1'b0));
      #1 bus.in_valid = 1'b0;

      // Backpressure: result must stay put while out_ready is low.
      wait_in_ready(ok);
      bus.out_ready = 1'b0;
      bus.data_A    = 32'd5;
      bus.data_B    = 32'd7;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      sb_q.push_back(mk({1'b1, 32'hFFFF_FFFE}, 1'b0));
      #1 bus.in_valid = 1'b0;
      gap = 0;
      while (gap < 20 && !bus.out_valid) begin
         @(negedge clk);
         gap++;
      end
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.data_A   = 32'(i + 100);
         @(negedge clk);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_result", 64'(bus.result), 64'h1_FFFF_FFFE);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_in_ready(ok);
      chk("bp_done_cleared", 64'(bus.out_valid), 64'd0);

      // Reset during the third RUN cycle aborts the operation silently.
      bus.data_A   = 32'h0000_1234;
      bus.data_B   = 32'd1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("post_rst_result", 64'(bus.result), 64'd0);

      run_op(32'd100, 32'd58, 33'h0_0000_002A, 1'b0, "sub_100_58");

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
